// File: rtl/cellrv32_irq_ctrl_pkg.sv
// Shared constants, CSR addresses, cause codes and the request FSM state type
// for the CPU-side interrupt controller.
package cellrv32_package;

    localparam logic [11:0] csr_mie_c = 12'h304;
    localparam logic [11:0] csr_mip_c = 12'h344;

    localparam logic [4:0] irq_msi_c   = 5'd3;
    localparam logic [4:0] irq_mti_c   = 5'd7;
    localparam logic [4:0] irq_mei_c   = 5'd11;
    localparam logic [4:0] irq_firq0_c = 5'd16;

    typedef enum logic [1:0] {
        IRQ_IDLE,
        IRQ_REQ,
        IRQ_SETTLE
    } irq_state_t;

    // Implemented mie/mip bits: MSI, MTI, MEI plus one bit per fast IRQ line.
    function automatic logic [31:0] irq_mask_f(input int num_firq);
        logic [31:0] mask;
        mask = 32'h0;
        mask[irq_msi_c] = 1'b1;
        mask[irq_mti_c] = 1'b1;
        mask[irq_mei_c] = 1'b1;
        for (int i = 0; i < num_firq; i++) begin
            mask[16 + i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/cellrv32_irq_ctrl_sync.sv
// Multi-stage synchronizer for an asynchronous IRQ line, with a rising-edge
// detector on the synchronized level.
module cellrv32_irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    // Shift the raw line through the chain; remember the last synced value for edge detection.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], async_i};
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_reg[SYNC_STAGES-1];
    assign rise_o  = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/cellrv32_irq_ctrl.sv
// CPU-side interrupt controller: mie/mip CSRs, priority selection and a
// committed req/ack trap request towards the CPU control unit.
// Optional fast-IRQ support is enabled by defining CELLRV32_IRQ_FIRQ_EN;
// without it firq_i is ignored and mie/mip[31:16] read as zero.
module cellrv32_irq_ctrl
    import cellrv32_package::*;
#(
    parameter int NUM_FIRQ    = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                csr_re_i,
    input  logic                csr_we_i,
    input  logic [11:0]         csr_addr_i,
    input  logic [31:0]         csr_wdata_i,
    output logic [31:0]         csr_rdata_o,
    input  logic                mstatus_mie_i,
    input  logic                mti_i,
    input  logic                msi_i,
    input  logic                mei_i,
    input  logic [NUM_FIRQ-1:0] firq_i,
    output logic                irq_req_o,
    output logic [4:0]          irq_cause_o,
    input  logic                irq_ack_i,
    output logic                wake_o
);

`ifdef CELLRV32_IRQ_FIRQ_EN
    localparam logic [31:0] irq_mask_c = irq_mask_f(NUM_FIRQ);
`else
    localparam logic [31:0] irq_mask_c = irq_mask_f(0);
    localparam int unused_num_firq = NUM_FIRQ;
`endif

    irq_state_t  state_reg, state_next;
    logic [31:0] mie_reg;
    logic        mti_reg, msi_reg, mei_reg;
    logic [31:0] mip_vec, pend;
    logic [4:0]  cause_reg, win_cause;
    logic        cause_load;
    logic        wake_reg;
    logic [31:0] rdata_reg;
    logic        mei_level, mei_rise_unused;

    // External IRQ is asynchronous: synchronize, use the level output.
    cellrv32_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mei_sync (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .async_i (mei_i),
        .level_o (mei_level),
        .rise_o  (mei_rise_unused)
    );

`ifdef CELLRV32_IRQ_FIRQ_EN
    logic [NUM_FIRQ-1:0] firq_rise, firq_level_unused;
    logic [NUM_FIRQ-1:0] firq_ack_clr, firq_wr_clr, firq_pend_reg;
    logic                ack_take;

    assign ack_take    = (state_reg == IRQ_REQ) && irq_ack_i;
    assign firq_wr_clr = (csr_we_i && (csr_addr_i == csr_mip_c)) ? ~csr_wdata_i[16 +: NUM_FIRQ] : '0;

    for (genvar gi = 0; gi < NUM_FIRQ; gi++) begin : g_firq
        cellrv32_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_firq_sync (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .async_i (firq_i[gi]),
            .level_o (firq_level_unused[gi]),
            .rise_o  (firq_rise[gi])
        );
        assign firq_ack_clr[gi] = ack_take && (cause_reg == 5'(irq_firq0_c + gi));
    end

    // Pending bits: a new edge always wins over a CSR clear or an ack clear.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            firq_pend_reg <= '0;
        end else begin
            firq_pend_reg <= (firq_pend_reg & ~(firq_wr_clr | firq_ack_clr)) | firq_rise;
        end
    end
`else
    logic unused_firq;
    assign unused_firq = ^firq_i;
`endif

    // Assemble the mip view from the level sources and the fast-IRQ pending bits.
    always_comb begin
        mip_vec            = 32'h0;
        mip_vec[irq_msi_c] = msi_reg;
        mip_vec[irq_mti_c] = mti_reg;
        mip_vec[irq_mei_c] = mei_reg;
`ifdef CELLRV32_IRQ_FIRQ_EN
        mip_vec[16 +: NUM_FIRQ] = firq_pend_reg;
`endif
    end

    assign pend = mip_vec & mie_reg;

    // Priority encoder: later assignments override, so the last one has the highest priority.
    always_comb begin
        win_cause = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pend[16 + i]) begin
                win_cause = 5'(16 + i);
            end
        end
        if (pend[irq_mti_c]) win_cause = irq_mti_c;
        if (pend[irq_msi_c]) win_cause = irq_msi_c;
        if (pend[irq_mei_c]) win_cause = irq_mei_c;
    end

    // Level source capture, mie write, registered CSR read and wake flag.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mti_reg   <= 1'b0;
            msi_reg   <= 1'b0;
            mei_reg   <= 1'b0;
            mie_reg   <= 32'h0;
            rdata_reg <= 32'h0;
            wake_reg  <= 1'b0;
        end else begin
            mti_reg  <= mti_i;
            msi_reg  <= msi_i;
            mei_reg  <= mei_level;
            wake_reg <= |pend;
            if (csr_we_i && (csr_addr_i == csr_mie_c)) begin
                mie_reg <= csr_wdata_i & irq_mask_c;
            end
            if (csr_re_i && (csr_addr_i == csr_mie_c)) begin
                rdata_reg <= mie_reg;
            end else if (csr_re_i && (csr_addr_i == csr_mip_c)) begin
                rdata_reg <= mip_vec;
            end else begin
                rdata_reg <= 32'h0;
            end
        end
    end

    // Request FSM state register and frozen cause.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= IRQ_IDLE;
            cause_reg <= 5'd0;
        end else begin
            state_reg <= state_next;
            if (cause_load) begin
                cause_reg <= win_cause;
            end
        end
    end

    // Next-state logic: a request, once raised, is held until the CPU acks it.
    always_comb begin
        state_next = state_reg;
        cause_load = 1'b0;
        case (state_reg)
            IRQ_IDLE: begin
                if (mstatus_mie_i && (|pend)) begin
                    state_next = IRQ_REQ;
                    cause_load = 1'b1;
                end
            end
            IRQ_REQ: begin
                if (irq_ack_i) begin
                    state_next = IRQ_SETTLE;
                end
            end
            IRQ_SETTLE: state_next = IRQ_IDLE;
            default:    state_next = IRQ_IDLE;
        endcase
    end

    assign irq_req_o   = (state_reg == IRQ_REQ);
    assign irq_cause_o = cause_reg;
    assign csr_rdata_o = rdata_reg;
    assign wake_o      = wake_reg;

endmodule

// File: tb/tb_cellrv32_irq_ctrl.sv
// Directed self-checking bench for cellrv32_irq_ctrl. Expected causes and CSR
// read values are queued when stimulus is driven and compared on DUT output.
module tb_cellrv32_irq_ctrl;
    import cellrv32_package::*;

    localparam int NUM_FIRQ    = 16;
    localparam int SYNC_STAGES = 2;
`ifdef CELLRV32_IRQ_FIRQ_EN
    localparam logic [31:0] MIE_ALL = 32'hFFFF_0888;
`else
    localparam logic [31:0] MIE_ALL = 32'h0000_0888;
`endif

    logic                clk = 1'b0;
    logic                rstn = 1'b0;
    logic                csr_re = 1'b0;
    logic                csr_we = 1'b0;
    logic [11:0]         csr_addr = 12'h0;
    logic [31:0]         csr_wdata = 32'h0;
    logic [31:0]         csr_rdata;
    logic                mstatus_mie = 1'b0;
    logic                mti = 1'b0;
    logic                msi = 1'b0;
    logic                mei = 1'b0;
    logic [NUM_FIRQ-1:0] firq = '0;
    logic                irq_req;
    logic [4:0]          irq_cause;
    logic                irq_ack = 1'b0;
    logic                wake;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] rd_q[$];
    logic [31:0] cause_q[$];

    always #5 clk = ~clk;

    cellrv32_irq_ctrl #(.NUM_FIRQ(NUM_FIRQ), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .csr_re_i      (csr_re),
        .csr_we_i      (csr_we),
        .csr_addr_i    (csr_addr),
        .csr_wdata_i   (csr_wdata),
        .csr_rdata_o   (csr_rdata),
        .mstatus_mie_i (mstatus_mie),
        .mti_i         (mti),
        .msi_i         (msi),
        .mei_i         (mei),
        .firq_i        (firq),
        .irq_req_o     (irq_req),
        .irq_cause_o   (irq_cause),
        .irq_ack_i     (irq_ack),
        .wake_o        (wake)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
            $display("check %s ok: 0x%08h", tag, obs);
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        csr_we    = 1'b1;
        csr_addr  = addr;
        csr_wdata = data;
        tick(1);
        csr_we    = 1'b0;
    endtask

    task automatic csr_read(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        rd_q.push_back(exp);
        csr_re   = 1'b1;
        csr_addr = addr;
        tick(1);
        csr_re   = 1'b0;
        check(tag, csr_rdata, rd_q.pop_front());
    endtask

    // Wait (bounded) for a request and compare its cause with the scoreboard head.
    task automatic wait_req(input string tag);
        int waited = 0;
        while (irq_req !== 1'b1 && waited < 40) begin
            tick(1);
            waited++;
        end
        check({tag, " req"}, {31'h0, irq_req}, 32'h1);
        if (cause_q.size() > 0) begin
            check({tag, " cause"}, {27'h0, irq_cause}, cause_q.pop_front());
        end else begin
            n_checks++;
            n_errors++;
            $error("FAIL %s cause: observed 0x%02h expected none queued", tag, irq_cause);
        end
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick(1);
        irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        check("rst req", {31'h0, irq_req}, 32'h0);
        check("rst cause", {27'h0, irq_cause}, 32'h0);
        check("rst rdata", csr_rdata, 32'h0);
        check("rst wake", {31'h0, wake}, 32'h0);
        rstn = 1'b1;
        tick(1);

        // Writable mie bits only
        csr_write(csr_mie_c, 32'hFFFF_FFFF);
        csr_read("mie mask", csr_mie_c, MIE_ALL);

        // 1: timer pulse, exact latency, hold until ack, low in SETTLE
        csr_write(csr_mie_c, 32'h80);
        mstatus_mie = 1'b1;
        cause_q.push_back(32'(irq_mti_c));
        mti = 1'b1;
        tick(1);
        check("t1 req N+1", {31'h0, irq_req}, 32'h0);
        mti = 1'b0;
        tick(1);
        check("t1 req N+2", {31'h0, irq_req}, 32'h1);
        check("t1 cause", {27'h0, irq_cause}, cause_q.pop_front());
        check("t1 wake", {31'h0, wake}, 32'h1);
        tick(3);
        check("t1 held req", {31'h0, irq_req}, 32'h1);
        ack();
        check("t1 settle req", {31'h0, irq_req}, 32'h0);
        tick(2);
        check("t1 idle req", {31'h0, irq_req}, 32'h0);

        // 2: priority MEI > MSI > MTI
        mstatus_mie = 1'b0;
        csr_write(csr_mie_c, 32'h888);
        mti = 1'b1;
        msi = 1'b1;
        mei = 1'b1;
        tick(SYNC_STAGES + 3);
        csr_read("t2 mip", csr_mip_c, 32'h888);
        check("t2 wake", {31'h0, wake}, 32'h1);
        check("t2 no req", {31'h0, irq_req}, 32'h0);
        cause_q.push_back(32'(irq_mei_c));
        cause_q.push_back(32'(irq_msi_c));
        cause_q.push_back(32'(irq_mti_c));
        mstatus_mie = 1'b1;
        wait_req("t2 first");
        mei = 1'b0;
        tick(SYNC_STAGES + 2);
        check("t2 mei held", {27'h0, irq_cause}, 32'(irq_mei_c));
        ack();
        wait_req("t2 second");
        msi = 1'b0;
        tick(2);
        ack();
        wait_req("t2 third");
        mti = 1'b0;
        tick(2);
        ack();
        tick(3);
        check("t2 done req", {31'h0, irq_req}, 32'h0);

        // 5: committed request survives source drop and mie clear
        csr_write(csr_mie_c, 32'h80);
        cause_q.push_back(32'(irq_mti_c));
        mti = 1'b1;
        wait_req("t5");
        mti = 1'b0;
        csr_write(csr_mie_c, 32'h0);
        tick(3);
        check("t5 req kept", {31'h0, irq_req}, 32'h1);
        check("t5 cause kept", {27'h0, irq_cause}, 32'(irq_mti_c));
        csr_read("t5 mie", csr_mie_c, 32'h0);
        ack();
        tick(3);
        check("t5 after req", {31'h0, irq_req}, 32'h0);
        check("t5 after wake", {31'h0, wake}, 32'h0);

`ifdef CELLRV32_IRQ_FIRQ_EN
        // 3: fast IRQ pending, wake without global enable, then request
        mstatus_mie = 1'b0;
        csr_write(csr_mie_c, 32'h1_0000);
        firq[0] = 1'b1;
        tick(1);
        firq[0] = 1'b0;
        tick(SYNC_STAGES + 1);
        check("t3 wake", {31'h0, wake}, 32'h1);
        check("t3 no req", {31'h0, irq_req}, 32'h0);
        csr_read("t3 mip set", csr_mip_c, 32'h1_0000);
        cause_q.push_back(32'(irq_firq0_c));
        mstatus_mie = 1'b1;
        wait_req("t3");
        ack();
        tick(1);
        csr_read("t3 mip acked", csr_mip_c, 32'h0);
        check("t3 idle req", {31'h0, irq_req}, 32'h0);

        // 4: edge coinciding with a clearing write to mip
        mstatus_mie = 1'b0;
        firq[2] = 1'b1;
        tick(SYNC_STAGES);
        csr_write(csr_mip_c, 32'h0);
        firq[2] = 1'b0;
        csr_read("t4 set wins", csr_mip_c, 32'h4_0000);
        csr_write(csr_mip_c, 32'h0);
        csr_read("t4 cleared", csr_mip_c, 32'h0);
        mstatus_mie = 1'b1;
`else
        // Fast IRQs absent: lines are ignored
        csr_write(csr_mie_c, 32'hFFFF_0000);
        firq = '1;
        tick(1);
        firq = '0;
        tick(SYNC_STAGES + 3);
        csr_read("nofirq mip", csr_mip_c, 32'h0);
        check("nofirq wake", {31'h0, wake}, 32'h0);
        check("nofirq req", {31'h0, irq_req}, 32'h0);
`endif

        // 6: async reset mid-request
        csr_write(csr_mie_c, 32'h80);
        cause_q.push_back(32'(irq_mti_c));
        mti = 1'b1;
        wait_req("t6");
        #2;
        rstn = 1'b0;
        #1;
        check("t6 req dropped", {31'h0, irq_req}, 32'h0);
        check("t6 cause reset", {27'h0, irq_cause}, 32'h0);
        check("t6 wake reset", {31'h0, wake}, 32'h0);
        mti = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(1);
        csr_read("t6 mie", csr_mie_c, 32'h0);
        csr_read("t6 mip", csr_mip_c, 32'h0);
        ack();
        check("t6 stray ack req", {31'h0, irq_req}, 32'h0);
        tick(2);
        check("t6 stray ack cause", {27'h0, irq_cause}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
